// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS core: ALUOp codes, register-$0
// constant, default widths and the forwarding-select encoding.
package mips_pkg;

  localparam int DEFAULT_DATA_W = 32;
  localparam int DEFAULT_REG_W  = 5;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam logic [3:0] ALU_NOP  = 4'b0000;
  localparam logic [3:0] ALU_ADD  = 4'b0001;
  localparam logic [3:0] ALU_SUB  = 4'b0010;
  localparam logic [3:0] ALU_AND  = 4'b0011;
  localparam logic [3:0] ALU_OR   = 4'b0100;
  localparam logic [3:0] ALU_MULT = 4'b0101;
  localparam logic [3:0] ALU_XOR  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_BEQ  = 4'b1001;
  localparam logic [3:0] ALU_JUMP = 4'b1010;
  localparam logic [3:0] ALU_LW   = 4'b1011;
  localparam logic [3:0] ALU_SW   = 4'b1100;
  localparam logic [3:0] ALU_ADDI = 4'b1101;

  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b01;

endpackage

// File: rtl/forward_unit.sv
// Forwarding select generation for two source registers. The youngest
// producer (EX/MEM) wins over MEM/WB; register $0 never forwards.
module forward_unit
  import mips_pkg::*;
#(
  parameter int REG_W = DEFAULT_REG_W
) (
  input  logic [REG_W-1:0] ex_rs,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             mem_regwrite,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             wb_regwrite,
  input  logic [REG_W-1:0] wb_rd,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b
);

  logic mem_ok;
  logic wb_ok;

  // A stage can only forward if it writes a non-zero destination.
  always_comb begin
    mem_ok = mem_regwrite && (mem_rd != REG_ZERO);
    wb_ok  = wb_regwrite && (wb_rd != REG_ZERO);
  end

  // Pick the source for each operand, newest producer first.
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (mem_ok && (mem_rd == ex_rs)) begin
      fwd_a = FWD_MEM;
    end else if (wb_ok && (wb_rd == ex_rs)) begin
      fwd_a = FWD_WB;
    end
    if (mem_ok && (mem_rd == ex_rt)) begin
      fwd_b = FWD_MEM;
    end else if (wb_ok && (wb_rd == ex_rt)) begin
      fwd_b = FWD_WB;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded operands/control, detects
// load-use hazards, inserts bubbles on stall/flush and forwards operands.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int REG_W  = DEFAULT_REG_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [3:0]        id_aluop,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_alusrc,
  input  logic              id_regdst,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_memwrite,
  input  logic              id_memtoreg,
  input  logic              flush,
  input  logic              mem_regwrite,
  input  logic [REG_W-1:0]  mem_rd,
  input  logic [DATA_W-1:0] mem_result,
  input  logic              wb_regwrite,
  input  logic [REG_W-1:0]  wb_rd,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall,
  output logic              ex_valid,
  output logic [3:0]        ex_aluop,
  output logic [DATA_W-1:0] ex_a,
  output logic [DATA_W-1:0] ex_b,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_W-1:0]  ex_dst,
  output logic              ex_regwrite,
  output logic              ex_memread,
  output logic              ex_memwrite,
  output logic              ex_memtoreg
);

  logic              valid_q, valid_d;
  logic [3:0]        aluop_q, aluop_d;
  logic [REG_W-1:0]  rs_q, rs_d;
  logic [REG_W-1:0]  rt_q, rt_d;
  logic [REG_W-1:0]  dst_q, dst_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d;
  logic [DATA_W-1:0] rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  logic              alusrc_q, alusrc_d;
  logic              regwrite_q, regwrite_d;
  logic              memread_q, memread_d;
  logic              memwrite_q, memwrite_d;
  logic              memtoreg_q, memtoreg_d;

  logic              load_use_hz;
  logic              wb_hits_rs;
  logic              wb_hits_rt;
  logic [1:0]        fwd_a;
  logic [1:0]        fwd_b;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in EX whose destination feeds the ID instruction must stall one cycle.
  always_comb begin
    load_use_hz = valid_q && memread_q && (dst_q != REG_ZERO) && id_valid &&
                  ((dst_q == id_rs) ||
                   ((dst_q == id_rt) && (!id_alusrc || id_memwrite)));
    stall = load_use_hz && !flush;
  end

  // Write-back in this cycle is not yet visible in the register file read.
  always_comb begin
    wb_hits_rs = wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rs);
    wb_hits_rt = wb_regwrite && (wb_rd != REG_ZERO) && (wb_rd == id_rt);
  end

  // Next EX contents: a cleared bubble on flush or hazard, else the ID fields.
  always_comb begin
    valid_d    = 1'b0;
    aluop_d    = ALU_NOP;
    rs_d       = '0;
    rt_d       = '0;
    dst_d      = '0;
    rs_data_d  = '0;
    rt_data_d  = '0;
    imm_d      = '0;
    alusrc_d   = 1'b0;
    regwrite_d = 1'b0;
    memread_d  = 1'b0;
    memwrite_d = 1'b0;
    memtoreg_d = 1'b0;
    if (!flush && !load_use_hz) begin
      valid_d    = id_valid;
      aluop_d    = id_aluop;
      rs_d       = id_rs;
      rt_d       = id_rt;
      dst_d      = id_regdst ? id_rd : id_rt;
      rs_data_d  = wb_hits_rs ? wb_data : id_rs_data;
      rt_data_d  = wb_hits_rt ? wb_data : id_rt_data;
      imm_d      = id_imm;
      alusrc_d   = id_alusrc;
      regwrite_d = id_regwrite && id_valid;
      memread_d  = id_memread && id_valid;
      memwrite_d = id_memwrite && id_valid;
      memtoreg_d = id_memtoreg;
    end
  end

  // EX register bank with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      aluop_q    <= ALU_NOP;
      rs_q       <= '0;
      rt_q       <= '0;
      dst_q      <= '0;
      rs_data_q  <= '0;
      rt_data_q  <= '0;
      imm_q      <= '0;
      alusrc_q   <= 1'b0;
      regwrite_q <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      aluop_q    <= aluop_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      dst_q      <= dst_d;
      rs_data_q  <= rs_data_d;
      rt_data_q  <= rt_data_d;
      imm_q      <= imm_d;
      alusrc_q   <= alusrc_d;
      regwrite_q <= regwrite_d;
      memread_q  <= memread_d;
      memwrite_q <= memwrite_d;
      memtoreg_q <= memtoreg_d;
    end
  end

  forward_unit #(
    .REG_W(REG_W)
  ) u_forward_unit (
    .ex_rs        (rs_q),
    .ex_rt        (rt_q),
    .mem_regwrite (mem_regwrite),
    .mem_rd       (mem_rd),
    .wb_regwrite  (wb_regwrite),
    .wb_rd        (wb_rd),
    .fwd_a        (fwd_a),
    .fwd_b        (fwd_b)
  );

  // Resolve the final operand values from the forwarding selects.
  always_comb begin
    case (fwd_a)
      FWD_MEM: rs_fwd = mem_result;
      FWD_WB:  rs_fwd = wb_data;
      default: rs_fwd = rs_data_q;
    endcase
    case (fwd_b)
      FWD_MEM: rt_fwd = mem_result;
      FWD_WB:  rt_fwd = wb_data;
      default: rt_fwd = rt_data_q;
    endcase
  end

  assign ex_valid      = valid_q;
  assign ex_aluop      = aluop_q;
  assign ex_a          = rs_fwd;
  assign ex_b          = alusrc_q ? imm_q : rt_fwd;
  assign ex_store_data = rt_fwd;
  assign ex_dst        = dst_q;
  assign ex_regwrite   = regwrite_q;
  assign ex_memread    = memread_q;
  assign ex_memwrite   = memwrite_q;
  assign ex_memtoreg   = memtoreg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed pipeline scenarios from a
// vector table, an asynchronous mid-stall reset sequence, then randomized
// traffic compared against an instruction-level reference model.
module tb_id_ex_stage;

   typedef struct {
      logic        id_valid;
      logic [3:0]  id_aluop;
      logic [31:0] id_rs_data;
      logic [31:0] id_rt_data;
      logic [31:0] id_imm;
      logic [4:0]  id_rs;
      logic [4:0]  id_rt;
      logic [4:0]  id_rd;
      logic        id_alusrc;
      logic        id_regdst;
      logic        id_regwrite;
      logic        id_memread;
      logic        id_memwrite;
      logic        id_memtoreg;
      logic        flush;
      logic        mem_regwrite;
      logic [4:0]  mem_rd;
      logic [31:0] mem_result;
      logic        wb_regwrite;
      logic [4:0]  wb_rd;
      logic [31:0] wb_data;
   } in_t;

   typedef struct {
      in_t         in;
      logic        stall;
      logic        valid;
      logic [3:0]  aluop;
      logic        chkData;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  dst;
      logic        memread;
   } vec_t;

   // Instruction sitting in EX, as the model sees it.
   typedef struct {
      logic        valid;
      logic [3:0]  aluop;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  dst;
      logic [31:0] rsVal;
      logic [31:0] rtVal;
      logic [31:0] imm;
      logic        alusrc;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        memtoreg;
   } ex_t;

   localparam int NUM_VEC = 15;

   logic        clk;
   logic        rst_n;
   logic        id_valid;
   logic [3:0]  id_aluop;
   logic [31:0] id_rs_data;
   logic [31:0] id_rt_data;
   logic [31:0] id_imm;
   logic [4:0]  id_rs;
   logic [4:0]  id_rt;
   logic [4:0]  id_rd;
   logic        id_alusrc;
   logic        id_regdst;
   logic        id_regwrite;
   logic        id_memread;
   logic        id_memwrite;
   logic        id_memtoreg;
   logic        flush;
   logic        mem_regwrite;
   logic [4:0]  mem_rd;
   logic [31:0] mem_result;
   logic        wb_regwrite;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        stall;
   logic        ex_valid;
   logic [3:0]  ex_aluop;
   logic [31:0] ex_a;
   logic [31:0] ex_b;
   logic [31:0] ex_store_data;
   logic [4:0]  ex_dst;
   logic        ex_regwrite;
   logic        ex_memread;
   logic        ex_memwrite;
   logic        ex_memtoreg;

   int   checks = 0;
   int   errors = 0;
   vec_t tbl[NUM_VEC];

   id_ex_stage dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .id_valid      (id_valid),
      .id_aluop      (id_aluop),
      .id_rs_data    (id_rs_data),
      .id_rt_data    (id_rt_data),
      .id_imm        (id_imm),
      .id_rs         (id_rs),
      .id_rt         (id_rt),
      .id_rd         (id_rd),
      .id_alusrc     (id_alusrc),
      .id_regdst     (id_regdst),
      .id_regwrite   (id_regwrite),
      .id_memread    (id_memread),
      .id_memwrite   (id_memwrite),
      .id_memtoreg   (id_memtoreg),
      .flush         (flush),
      .mem_regwrite  (mem_regwrite),
      .mem_rd        (mem_rd),
      .mem_result    (mem_result),
      .wb_regwrite   (wb_regwrite),
      .wb_rd         (wb_rd),
      .wb_data       (wb_data),
      .stall         (stall),
      .ex_valid      (ex_valid),
      .ex_aluop      (ex_aluop),
      .ex_a          (ex_a),
      .ex_b          (ex_b),
      .ex_store_data (ex_store_data),
      .ex_dst        (ex_dst),
      .ex_regwrite   (ex_regwrite),
      .ex_memread    (ex_memread),
      .ex_memwrite   (ex_memwrite),
      .ex_memtoreg   (ex_memtoreg)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // A pipeline slot with nothing in ID and nothing writing back.
   function automatic in_t idleIn();
      in_t r;
      r.id_valid = 0; r.id_aluop = 0; r.id_rs_data = 0; r.id_rt_data = 0;
      r.id_imm = 0; r.id_rs = 0; r.id_rt = 0; r.id_rd = 0;
      r.id_alusrc = 0; r.id_regdst = 0; r.id_regwrite = 0; r.id_memread = 0;
      r.id_memwrite = 0; r.id_memtoreg = 0; r.flush = 0;
      r.mem_regwrite = 0; r.mem_rd = 0; r.mem_result = 0;
      r.wb_regwrite = 0; r.wb_rd = 0; r.wb_data = 0;
      return r;
   endfunction

   // A valid decoded instruction in ID with idle MEM/WB stages.
   function automatic in_t mkId(input logic [3:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [31:0] rsD, input logic [31:0] rtD,
                                input logic [31:0] imm, input logic asrc, input logic rdst,
                                input logic rw, input logic mr, input logic mw, input logic m2r);
      in_t r;
      r = idleIn();
      r.id_valid = 1; r.id_aluop = op; r.id_rs = rs; r.id_rt = rt; r.id_rd = rd;
      r.id_rs_data = rsD; r.id_rt_data = rtD; r.id_imm = imm;
      r.id_alusrc = asrc; r.id_regdst = rdst; r.id_regwrite = rw;
      r.id_memread = mr; r.id_memwrite = mw; r.id_memtoreg = m2r;
      return r;
   endfunction

   // Value the ALU must see for a source register: newest in-flight writer wins.
   function automatic logic [31:0] newestValue(input logic [4:0] idx, input logic [31:0] held, input in_t r);
      if (idx != 0 && r.mem_regwrite && r.mem_rd == idx) return r.mem_result;
      if (idx != 0 && r.wb_regwrite && r.wb_rd == idx) return r.wb_data;
      return held;
   endfunction

   task automatic setRow(input int k, input in_t r, input logic st, input logic v, input logic [3:0] op,
                         input logic cd, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] d, input logic mr);
      tbl[k].in = r; tbl[k].stall = st; tbl[k].valid = v; tbl[k].aluop = op;
      tbl[k].chkData = cd; tbl[k].a = a; tbl[k].b = b; tbl[k].dst = d; tbl[k].memread = mr;
   endtask

   task automatic applyStimulus(input in_t r);
      id_valid = r.id_valid; id_aluop = r.id_aluop; id_rs_data = r.id_rs_data;
      id_rt_data = r.id_rt_data; id_imm = r.id_imm; id_rs = r.id_rs; id_rt = r.id_rt;
      id_rd = r.id_rd; id_alusrc = r.id_alusrc; id_regdst = r.id_regdst;
      id_regwrite = r.id_regwrite; id_memread = r.id_memread; id_memwrite = r.id_memwrite;
      id_memtoreg = r.id_memtoreg; flush = r.flush; mem_regwrite = r.mem_regwrite;
      mem_rd = r.mem_rd; mem_result = r.mem_result; wb_regwrite = r.wb_regwrite;
      wb_rd = r.wb_rd; wb_data = r.wb_data;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
      end
   endtask

   // Directed scenarios, mid-stall reset, then randomized model comparison.
   initial begin
      in_t r;
      ex_t m;
      ex_t nxt;
      logic hz;
      logic expStall;

      rst_n = 1'b1;
      applyStimulus(idleIn());
      #1 rst_n = 1'b0;
      #2;
      checkOutput("reset ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("reset ex_aluop", {28'b0, ex_aluop}, 32'd0);
      checkOutput("reset ex_a", ex_a, 32'd0);
      checkOutput("reset ex_b", ex_b, 32'd0);
      checkOutput("reset stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Each row is driven for one cycle; its expectations describe EX as
      // captured from the previous row, forwarded with this row's MEM/WB.
      r = mkId(4'h1, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h0, 0, 1, 1, 0, 0, 0);
      setRow(0, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      r = mkId(4'h2, 5'd3, 5'd5, 5'd4, 32'h111, 32'h7, 32'h0, 0, 1, 1, 0, 0, 0);
      setRow(1, r, 0, 1, 4'h1, 1, 32'h5, 32'h6, 5'd3, 0);
      r = idleIn(); r.mem_regwrite = 1; r.mem_rd = 3; r.mem_result = 32'h10;
      r.wb_regwrite = 1; r.wb_rd = 3; r.wb_data = 32'h99;
      setRow(2, r, 0, 1, 4'h2, 1, 32'h10, 32'h7, 5'd4, 0);
      r = mkId(4'hB, 5'd1, 5'd2, 5'd0, 32'h100, 32'h0, 32'h0, 1, 0, 1, 1, 0, 1);
      setRow(3, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      r = mkId(4'h1, 5'd2, 5'd6, 5'd5, 32'h222, 32'h60, 32'h0, 0, 1, 1, 0, 0, 0);
      setRow(4, r, 1, 1, 4'hB, 1, 32'h100, 32'h0, 5'd2, 1);
      r.mem_regwrite = 1; r.mem_rd = 2; r.mem_result = 32'h100;
      setRow(5, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      r = idleIn(); r.wb_regwrite = 1; r.wb_rd = 2; r.wb_data = 32'hCAFE;
      setRow(6, r, 0, 1, 4'h1, 1, 32'hCAFE, 32'h60, 5'd5, 0);
      r = mkId(4'hB, 5'd3, 5'd4, 5'd0, 32'h200, 32'h0, 32'h4, 1, 0, 1, 1, 0, 1);
      setRow(7, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      r = mkId(4'h2, 5'd4, 5'd4, 5'd6, 32'h444, 32'h444, 32'h0, 0, 1, 1, 0, 0, 0);
      r.flush = 1;
      setRow(8, r, 0, 1, 4'hB, 1, 32'h200, 32'h4, 5'd4, 1);
      r = mkId(4'h4, 5'd1, 5'd2, 5'd7, 32'h0F, 32'hF0, 32'h0, 0, 1, 1, 0, 0, 0);
      setRow(9, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      setRow(10, idleIn(), 0, 1, 4'h4, 1, 32'h0F, 32'hF0, 5'd7, 0);
      r = mkId(4'h1, 5'd0, 5'd1, 5'd9, 32'h0, 32'h3, 32'h0, 0, 1, 1, 0, 0, 0);
      setRow(11, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      r = idleIn(); r.mem_regwrite = 1; r.mem_rd = 0; r.mem_result = 32'hFFFF_FFFF;
      r.wb_regwrite = 1; r.wb_rd = 0; r.wb_data = 32'h1234;
      setRow(12, r, 0, 1, 4'h1, 1, 32'h0, 32'h3, 5'd9, 0);
      r = mkId(4'hD, 5'd8, 5'd7, 5'd0, 32'h555, 32'h0, 32'hFFFF_FFFC, 1, 0, 1, 0, 0, 0);
      r.wb_regwrite = 1; r.wb_rd = 8; r.wb_data = 32'h20;
      setRow(13, r, 0, 0, 4'h0, 0, 0, 0, 0, 0);
      setRow(14, idleIn(), 0, 1, 4'hD, 1, 32'h20, 32'hFFFF_FFFC, 5'd7, 0);

      for (int k = 0; k < NUM_VEC; k++) begin
         applyStimulus(tbl[k].in);
         @(negedge clk);
         checkOutput($sformatf("vec%0d stall", k), {31'b0, stall}, {31'b0, tbl[k].stall});
         checkOutput($sformatf("vec%0d ex_valid", k), {31'b0, ex_valid}, {31'b0, tbl[k].valid});
         checkOutput($sformatf("vec%0d ex_aluop", k), {28'b0, ex_aluop}, {28'b0, tbl[k].aluop});
         checkOutput($sformatf("vec%0d ex_memread", k), {31'b0, ex_memread}, {31'b0, tbl[k].memread});
         if (tbl[k].chkData) begin
            checkOutput($sformatf("vec%0d ex_a", k), ex_a, tbl[k].a);
            checkOutput($sformatf("vec%0d ex_b", k), ex_b, tbl[k].b);
            checkOutput($sformatf("vec%0d ex_dst", k), {27'b0, ex_dst}, {27'b0, tbl[k].dst});
         end
         @(posedge clk);
         #1;
      end

      // Reset while a load-use stall is being asserted.
      applyStimulus(mkId(4'hB, 5'd1, 5'd2, 5'd0, 32'h300, 32'h0, 32'h8, 1, 0, 1, 1, 0, 1));
      @(posedge clk);
      #1;
      applyStimulus(mkId(4'h1, 5'd2, 5'd6, 5'd5, 32'h222, 32'h60, 32'h0, 0, 1, 1, 0, 0, 0));
      #1;
      checkOutput("pre-reset stall", {31'b0, stall}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midreset stall", {31'b0, stall}, 32'd0);
      checkOutput("midreset ex_valid", {31'b0, ex_valid}, 32'd0);
      checkOutput("midreset ex_aluop", {28'b0, ex_aluop}, 32'd0);
      checkOutput("midreset ex_a", ex_a, 32'd0);
      checkOutput("midreset ex_b", ex_b, 32'd0);
      checkOutput("midreset ex_memread", {31'b0, ex_memread}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      checkOutput("recapture ex_valid", {31'b0, ex_valid}, 32'd1);
      checkOutput("recapture ex_aluop", {28'b0, ex_aluop}, 32'd1);
      checkOutput("recapture ex_a", ex_a, 32'h222);
      checkOutput("recapture ex_dst", {27'b0, ex_dst}, 32'd5);

      // Clean restart so the model and DUT begin from the same empty EX.
      rst_n = 1'b0;
      applyStimulus(idleIn());
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      m = '{default: '0};

      for (int n = 0; n < 400; n++) begin
         r.id_valid     = ($urandom_range(0, 3) != 0);
         r.id_aluop     = 4'($urandom_range(0, 13));
         r.id_rs_data   = $urandom;
         r.id_rt_data   = $urandom;
         r.id_imm       = $urandom;
         r.id_rs        = 5'($urandom_range(0, 3));
         r.id_rt        = 5'($urandom_range(0, 3));
         r.id_rd        = 5'($urandom_range(0, 3));
         r.id_alusrc    = 1'($urandom_range(0, 1));
         r.id_regdst    = 1'($urandom_range(0, 1));
         r.id_regwrite  = 1'($urandom_range(0, 1));
         r.id_memread   = ($urandom_range(0, 2) == 0);
         r.id_memwrite  = ($urandom_range(0, 3) == 0);
         r.id_memtoreg  = 1'($urandom_range(0, 1));
         r.flush        = ($urandom_range(0, 7) == 0);
         r.mem_regwrite = 1'($urandom_range(0, 1));
         r.mem_rd       = 5'($urandom_range(0, 3));
         r.mem_result   = $urandom;
         r.wb_regwrite  = 1'($urandom_range(0, 1));
         r.wb_rd        = 5'($urandom_range(0, 3));
         r.wb_data      = $urandom;
         applyStimulus(r);

         hz = m.valid && m.memread && m.dst != 0 && r.id_valid &&
              (m.dst == r.id_rs || (m.dst == r.id_rt && (!r.id_alusrc || r.id_memwrite)));
         expStall = hz && !r.flush;

         @(negedge clk);
         checkOutput("rand stall", {31'b0, stall}, {31'b0, expStall});
         checkOutput("rand ex_valid", {31'b0, ex_valid}, {31'b0, m.valid});
         checkOutput("rand ex_aluop", {28'b0, ex_aluop}, {28'b0, m.aluop});
         checkOutput("rand ex_regwrite", {31'b0, ex_regwrite}, {31'b0, m.regwrite});
         checkOutput("rand ex_memread", {31'b0, ex_memread}, {31'b0, m.memread});
         checkOutput("rand ex_memwrite", {31'b0, ex_memwrite}, {31'b0, m.memwrite});
         checkOutput("rand ex_memtoreg", {31'b0, ex_memtoreg}, {31'b0, m.memtoreg});
         if (m.valid) begin
            checkOutput("rand ex_a", ex_a, newestValue(m.rs, m.rsVal, r));
            checkOutput("rand ex_b", ex_b, m.alusrc ? m.imm : newestValue(m.rt, m.rtVal, r));
            checkOutput("rand ex_store_data", ex_store_data, newestValue(m.rt, m.rtVal, r));
            checkOutput("rand ex_dst", {27'b0, ex_dst}, {27'b0, m.dst});
         end

         nxt = '{default: '0};
         if (!r.flush && !hz) begin
            nxt.valid    = r.id_valid;
            nxt.aluop    = r.id_aluop;
            nxt.rs       = r.id_rs;
            nxt.rt       = r.id_rt;
            nxt.dst      = r.id_regdst ? r.id_rd : r.id_rt;
            nxt.rsVal    = (r.wb_regwrite && r.wb_rd != 0 && r.wb_rd == r.id_rs) ? r.wb_data : r.id_rs_data;
            nxt.rtVal    = (r.wb_regwrite && r.wb_rd != 0 && r.wb_rd == r.id_rt) ? r.wb_data : r.id_rt_data;
            nxt.imm      = r.id_imm;
            nxt.alusrc   = r.id_alusrc;
            nxt.regwrite = r.id_regwrite && r.id_valid;
            nxt.memread  = r.id_memread && r.id_valid;
            nxt.memwrite = r.id_memwrite && r.id_valid;
            nxt.memtoreg = r.id_memtoreg;
         end
         m = nxt;

         @(posedge clk);
         #1;
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
